// File: rtl/fu_issue.sv
// fu_issue: operation queue and issue stage for a single functional unit.
// Ops are accepted into a small FIFO, presented to the FU one per cycle, and
// their results are collected after the op-class latency. An idle bubble
// follows a MADD-class op when the next op has a shorter latency, so that
// two results can never land on the same edge.
//
// Ports
//   clock, reset          single clock, synchronous active-high reset
//   in_valid / in_ready   upstream handshake (accept when both are 1)
//   in_a/in_b/in_c        32-bit operands
//   in_inst, in_select    opcode and select bit
//   in_tag                opaque identifier returned with the result
//   fu_a/fu_b/fu_c        operands to the FU (posedge registers)
//   fu_inst               opcode to the FU (falling-edge copy)
//   fu_select             select bit to the FU
//   fu_z, fu_compare      FU data result and compare flag
//   out_valid/out_z/out_compare/out_tag   result return, no backpressure
//
// Bubble FSM
//   state  | meaning
//   RUN    | normal issue, head popped whenever the FIFO is non-empty
//   BUBBLE | idle op presented after a MADD-class op, next head may issue

module fu_issue #(
  parameter int DEPTH    = 4,
  parameter int MADD_LAT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [31:0] in_c,
  input  logic [5:0]  in_inst,
  input  logic        in_select,
  input  logic [3:0]  in_tag,
  output logic [31:0] fu_a,
  output logic [31:0] fu_b,
  output logic [31:0] fu_c,
  output logic [5:0]  fu_inst,
  output logic        fu_select,
  input  logic [31:0] fu_z,
  input  logic        fu_compare,
  output logic        out_valid,
  output logic [31:0] out_z,
  output logic        out_compare,
  output logic [3:0]  out_tag
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(MADD_LAT + 1);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [5:0]  inst;
    logic        sel;
    logic [3:0]  tag;
  } entry_t;

  typedef enum logic {RUN, BUBBLE} state_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic            empty;
  entry_t          head;
  logic            head_madd;
  logic            last_madd;
  logic            need_bubble;
  state_t          state_q;
  state_t          state_d;
  logic [5:0]      inst_q;
  logic [TW-1:0]   ins_idx;
  logic            trk_v   [MADD_LAT+1];
  logic [3:0]      trk_tag [MADD_LAT+1];

  // ---------------- FIFO ----------------
  assign in_ready  = !reset && (count < CW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign empty     = (count == '0);
  assign head      = mem[rd_ptr];
  assign head_madd = (head.inst[5:3] == 3'b111);

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= '{a: in_a, b: in_b, c: in_c, inst: in_inst,
                       sel: in_select, tag: in_tag};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- bubble FSM ----------------
  // A short-latency op directly behind a MADD-class op would retire on the
  // same edge as the MADD, so one idle slot is inserted between them.
  assign need_bubble = !empty && last_madd && !head_madd;

  always_ff @(posedge clock) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     state_d = need_bubble ? BUBBLE : RUN;
      BUBBLE:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pop = 1'b0;
    case (state_q)
      RUN:     pop = !empty && !need_bubble;
      BUBBLE:  pop = !empty;
      default: pop = 1'b0;
    endcase
  end

  // ---------------- FU registers ----------------
  always_ff @(posedge clock) begin
    if (reset || !pop) begin
      fu_a      <= '0;
      fu_b      <= '0;
      fu_c      <= '0;
      fu_select <= 1'b0;
      inst_q    <= '0;
      last_madd <= 1'b0;
    end else begin
      fu_a      <= head.a;
      fu_b      <= head.b;
      fu_c      <= head.c;
      fu_select <= head.sel;
      inst_q    <= head.inst;
      last_madd <= head_madd;
    end
  end

  // Opcode moves only in the low phase of the clock.
  always_ff @(negedge clock) begin
    fu_inst <= inst_q;
  end

  // ---------------- result tracking ----------------
  // Slot i retires i+1 edges from now; a presented op is sampled one edge
  // later and retires latency edges after that, hence slot = latency.
  assign ins_idx = head_madd ? TW'(MADD_LAT) : TW'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i <= MADD_LAT; i++) begin
        trk_v[i]   <= 1'b0;
        trk_tag[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MADD_LAT; i++) begin
        trk_v[i]   <= trk_v[i+1];
        trk_tag[i] <= trk_tag[i+1];
      end
      trk_v[MADD_LAT]   <= 1'b0;
      trk_tag[MADD_LAT] <= '0;
      if (pop) begin
        trk_v[ins_idx]   <= 1'b1;
        trk_tag[ins_idx] <= head.tag;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_z       <= '0;
      out_compare <= 1'b0;
      out_tag     <= '0;
    end else begin
      out_valid <= trk_v[0];
      if (trk_v[0]) begin
        out_z       <= fu_z;
        out_compare <= fu_compare;
        out_tag     <= trk_tag[0];
      end
    end
  end

endmodule

// File: tb/tb_fu_issue.sv
module tb_fu_issue;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b, in_c;
  logic [5:0]  in_inst;
  logic        in_select;
  logic [3:0]  in_tag;
  logic [31:0] fu_a, fu_b, fu_c;
  logic [5:0]  fu_inst;
  logic        fu_select;
  logic [31:0] fu_z;
  logic        fu_compare;
  logic        out_valid;
  logic [31:0] out_z;
  logic        out_compare;
  logic [3:0]  out_tag;

  always #5 clock = ~clock;

  fu_issue #(.DEPTH(4), .MADD_LAT(2)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .in_inst(in_inst), .in_select(in_select), .in_tag(in_tag),
    .fu_a(fu_a), .fu_b(fu_b), .fu_c(fu_c),
    .fu_inst(fu_inst), .fu_select(fu_select),
    .fu_z(fu_z), .fu_compare(fu_compare),
    .out_valid(out_valid), .out_z(out_z),
    .out_compare(out_compare), .out_tag(out_tag)
  );

  localparam logic [5:0] OP_ADD  = 6'b000010;
  localparam logic [5:0] OP_MADD = 6'b111100;
  localparam logic [5:0] OP_LT   = 6'b001110;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Functional-unit behaviour: {compare, z}
  function automatic logic [32:0] calc(input logic [5:0] inst, input logic [31:0] a,
                                       input logic [31:0] b, input logic [31:0] c);
    logic [31:0] z;
    logic        cmp;
    cmp = 1'b0;
    if (inst[5:3] == 3'b111)  z = a * b + c;
    else if (inst == OP_ADD)  z = a + b;
    else if (inst == OP_LT) begin
      cmp = ($signed(a) < $signed(b));
      z   = {31'b0, cmp};
    end else z = a ^ b;
    return {cmp, z};
  endfunction

  // FU model: samples its inputs on each posedge, result shows on fu_z for
  // the cycle ending at sample edge + latency.
  logic [32:0] zq [2];
  initial begin
    zq[0] = '0; zq[1] = '0;
    fu_z = '0; fu_compare = 1'b0;
  end
  always @(posedge clock) begin : fu_model
    logic [31:0] sa, sb, sc;
    logic [5:0]  si;
    sa = fu_a; sb = fu_b; sc = fu_c; si = fu_inst;
    #1;
    zq[0] = zq[1];
    zq[1] = '0;
    if (si != 6'd0) begin
      if (si[5:3] == 3'b111) zq[1] = calc(si, sa, sb, sc);
      else                   zq[0] = calc(si, sa, sb, sc);
    end
    fu_z       = zq[0][31:0];
    fu_compare = zq[0][32];
  end

  // Scoreboard: every accepted op must come back once, in order.
  typedef struct {
    logic [31:0] z;
    logic        cmp;
    logic [3:0]  tag;
  } exp_t;
  exp_t expq[$];

  always @(posedge clock) begin : monitor
    logic acc, rst;
    logic [32:0] r;
    exp_t e, f;
    acc = in_valid && in_ready;
    rst = reset;
    r = calc(in_inst, in_a, in_b, in_c);
    e.z = r[31:0]; e.cmp = r[32]; e.tag = in_tag;
    #1;
    if (rst) expq.delete();
    else if (out_valid === 1'b1) begin
      if (expq.size() == 0) chk("spurious_out_valid", 32'd1, 32'd0);
      else begin
        f = expq.pop_front();
        chk("sb_tag", 32'(out_tag), 32'(f.tag));
        chk("sb_z", out_z, f.z);
        chk("sb_cmp", 32'(out_compare), 32'(f.cmp));
      end
    end
    if (acc && !rst) expq.push_back(e);
  end

  always @(fu_inst) begin
    if ($time > 0) chk("fu_inst_low_phase", 32'(clock), 32'd0);
  end

  task automatic send(input logic [5:0] inst, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic sel, input logic [3:0] tag,
                      output bit stalled);
    int n;
    in_inst = inst; in_a = a; in_b = b; in_c = c; in_select = sel; in_tag = tag;
    in_valid = 1'b1;
    stalled = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clock); #1;
      n++;
      stalled = 1'b1;
    end
    if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clock); #1;
  endtask

  typedef struct {
    logic [5:0]  inst;
    logic [31:0] a, b, c;
    logic        sel;
    logic [3:0]  tag;
    logic [31:0] z;
    logic        cmp;
    int          lat;
  } vec_t;
  vec_t vecs[7];

  initial begin
    bit          st;
    int          hits, first, last, e;
    logic [5:0]  inst_hist [8];
    logic [31:0] la [6], lb [6];
    bit          saw_full;

    vecs[0] = '{OP_ADD,   32'd3, 32'd4, 32'd0, 1'b0, 4'd5, 32'd7, 1'b0, 3};
    vecs[1] = '{OP_MADD,  32'd2, 32'd3, 32'd10, 1'b1, 4'd1, 32'd16, 1'b0, 4};
    vecs[2] = '{OP_LT,    32'hFFFFFFFB, 32'd2, 32'd0, 1'b0, 4'd3, 32'd1, 1'b1, 3};
    vecs[3] = '{OP_LT,    32'd7, 32'd2, 32'd0, 1'b1, 4'd4, 32'd0, 1'b0, 3};
    vecs[4] = '{6'b111000, 32'h10000, 32'h10000, 32'd1, 1'b0, 4'd6, 32'd1, 1'b0, 4};
    vecs[5] = '{6'b000101, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'd0, 1'b1, 4'd7, 32'hFFFFFFFF, 1'b0, 3};
    vecs[6] = '{OP_LT,    32'h7FFFFFFF, 32'h80000000, 32'd0, 1'b0, 4'd8, 32'd0, 1'b0, 3};

    reset = 1'b1; in_valid = 1'b0;
    in_a = '0; in_b = '0; in_c = '0; in_inst = '0; in_select = 1'b0; in_tag = '0;

    // reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_z", out_z, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_out_cmp", 32'(out_compare), 32'd0);
    @(negedge clock); #1;
    chk("rst_fu_inst", 32'(fu_inst), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // single ops into an idle block: latency and values
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      in_inst = vecs[i].inst; in_a = vecs[i].a; in_b = vecs[i].b; in_c = vecs[i].c;
      in_select = vecs[i].sel; in_tag = vecs[i].tag; in_valid = 1'b1;
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(posedge clock); #1;
      in_valid = 1'b0;
      hits = 0; first = 0;
      for (int k = 1; k <= 6; k++) begin
        @(posedge clock); #1;
        if (k == 1) begin
          chk($sformatf("vec%0d_fu_a", i), fu_a, vecs[i].a);
          chk($sformatf("vec%0d_fu_sel", i), 32'(fu_select), 32'(vecs[i].sel));
        end
        if (k == 2) chk($sformatf("vec%0d_fu_inst", i), 32'(fu_inst), 32'(vecs[i].inst));
        if (out_valid === 1'b1) begin
          hits++;
          if (hits == 1) begin
            first = k;
            chk($sformatf("vec%0d_z", i), out_z, vecs[i].z);
            chk($sformatf("vec%0d_cmp", i), 32'(out_compare), 32'(vecs[i].cmp));
            chk($sformatf("vec%0d_tag", i), 32'(out_tag), 32'(vecs[i].tag));
          end
        end
      end
      chk($sformatf("vec%0d_hits", i), 32'(hits), 32'd1);
      chk($sformatf("vec%0d_lat", i), 32'(first), 32'(vecs[i].lat));
    end

    // MADD followed immediately by ADD: one idle slot, results one edge apart
    @(negedge clock);
    in_inst = OP_MADD; in_a = 32'd2; in_b = 32'd3; in_c = 32'd10; in_tag = 4'd1;
    in_select = 1'b0; in_valid = 1'b1;
    @(posedge clock); #1;
    in_inst = OP_ADD; in_a = 32'd5; in_b = 32'd6; in_c = 32'd0; in_tag = 4'd2;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock); #1;
    inst_hist[1] = fu_inst;
    for (int k = 2; k <= 7; k++) begin
      @(posedge clock); #1;
      if (k == 4) begin
        chk("ma_madd_valid", 32'(out_valid), 32'd1);
        chk("ma_madd_z", out_z, 32'd16);
        chk("ma_madd_tag", 32'(out_tag), 32'd1);
      end else if (k == 5) begin
        chk("ma_add_valid", 32'(out_valid), 32'd1);
        chk("ma_add_z", out_z, 32'd11);
        chk("ma_add_tag", 32'(out_tag), 32'd2);
      end else chk($sformatf("ma_quiet_k%0d", k), 32'(out_valid), 32'd0);
      @(negedge clock); #1;
      inst_hist[k] = fu_inst;
    end
    chk("ma_inst1", 32'(inst_hist[1]), 32'(OP_MADD));
    chk("ma_inst2_idle", 32'(inst_hist[2]), 32'd0);
    chk("ma_inst3", 32'(inst_hist[3]), 32'(OP_ADD));
    chk("ma_inst4_idle", 32'(inst_hist[4]), 32'd0);

    // stream of LT ops: results back-to-back starting 3 edges after the first accept
    la[0] = 32'd1;        lb[0] = 32'd2;
    la[1] = 32'd2;        lb[1] = 32'd1;
    la[2] = 32'hFFFFFFFF; lb[2] = 32'd0;
    la[3] = 32'd0;        lb[3] = 32'hFFFFFFFF;
    la[4] = 32'd5;        lb[4] = 32'd5;
    la[5] = 32'h80000000; lb[5] = 32'h7FFFFFFF;
    hits = 0; first = -1; last = -1; e = 0;
    for (int i = 0; i < 6; i++) begin
      send(OP_LT, la[i], lb[i], 32'd0, 1'b0, 4'(i + 9), st);
      chk($sformatf("lt%0d_no_stall", i), 32'(st), 32'd0);
      if (out_valid === 1'b1) begin
        hits++; if (first < 0) first = e; last = e;
      end
      e++;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clock); #1;
      if (out_valid === 1'b1) begin
        hits++; if (first < 0) first = e; last = e;
      end
      e++;
    end
    chk("lt_count", 32'(hits), 32'd6);
    chk("lt_first_edge", 32'(first), 32'd3);
    chk("lt_no_gaps", 32'(last - first), 32'd5);

    // alternating MADD/ADD fills the FIFO, then reset mid-stream
    saw_full = 1'b0;
    for (int i = 0; i < 12; i++) begin
      send((i % 2 == 0) ? OP_MADD : OP_ADD, 32'(i), 32'(i + 1), 32'd3, 1'b0, 4'(i), st);
      if (st) saw_full = 1'b1;
    end
    in_valid = 1'b0;
    chk("fill_in_ready_dropped", 32'(saw_full), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("after_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clock); #1;
    chk("after_rst_fu_inst", 32'(fu_inst), 32'd0);
    hits = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock); #1;
      if (out_valid === 1'b1) hits++;
    end
    chk("after_rst_no_out", 32'(hits), 32'd0);

    // random mix against the scoreboard
    for (int i = 0; i < 10000; i++) begin
      logic [5:0] op;
      case ($urandom_range(0, 4))
        0: op = {3'b111, 3'($urandom_range(0, 7))};
        1: op = OP_ADD;
        2: op = OP_LT;
        3: op = 6'($urandom_range(1, 63));
        default: op = OP_MADD;
      endcase
      send(op, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), 4'(i), st);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clock); #1;
      end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 100 && expq.size() != 0; k++) begin
      @(posedge clock); #1;
    end
    chk("random_drained", 32'(expq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
